// File: rtl/task_graph_streamer.sv
// Task-graph streamer: holds one application's NUM_V x NUM_V adjacency matrix
// and replays it row-major, one entry per two cycles, num_apps times.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting; matrix writes accepted; start sampled here
// PRESENT | first cycle of an entry; edge_count counts non-zero entries
// HOLD    | second cycle of an entry; advances col/row
// GAP     | one quiet cycle after the last entry of an application
// END     | app_end pulse
// TAIL    | repetition bookkeeping; restart or finish with done
module task_graph_streamer #(
  parameter int NUM_V = 4,
  parameter int W     = 32,
  parameter int AW    = (NUM_V > 1) ? $clog2(NUM_V) : 1,
  parameter int CW    = $clog2(NUM_V * NUM_V + 1)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_row,
  input  logic [AW-1:0] wr_col,
  input  logic [W-1:0]  wr_data,
  input  logic          start,
  input  logic [15:0]   num_apps,
  input  logic          abort,
  output logic [W-1:0]  task_array,
  output logic          root_task,
  output logic [AW-1:0] row,
  output logic [AW-1:0] col,
  output logic          app_end,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] edge_count
);

  localparam int DEPTH = NUM_V * NUM_V;
  localparam int AD    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST   = AW'(NUM_V - 1);
  localparam logic [AD-1:0] NV_A   = AD'(NUM_V);
  localparam logic [CW-1:0] EC_MAX = {CW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESENT,
    S_HOLD,
    S_GAP,
    S_END,
    S_TAIL
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] row_q, col_q;
  logic [CW-1:0] edge_q;
  logic [15:0]   rep_q;
  logic          root_q;
  logic          done_q;
  logic [AD-1:0] wr_addr, rd_addr;
  logic [W-1:0]  cur_word;
  logic          cur_nz;
  logic          last_entry;

  assign wr_addr    = AD'(wr_row) * NV_A + AD'(wr_col);
  assign rd_addr    = AD'(row_q) * NV_A + AD'(col_q);
  assign cur_word   = mem[rd_addr];
  assign cur_nz     = |cur_word;
  assign last_entry = (row_q == LAST) && (col_q == LAST);

  assign row        = row_q;
  assign col        = col_q;
  assign edge_count = edge_q;
  assign done       = done_q;

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and state-decoded outputs; abort overrides any transition
  always_comb begin
    state_d    = state_q;
    task_array = '0;
    root_task  = 1'b0;
    app_end    = 1'b0;
    busy       = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start && (num_apps != 16'd0)) state_d = S_PRESENT;
      end
      S_PRESENT: begin
        task_array = cur_word;
        root_task  = cur_nz && (edge_q == '0);
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        task_array = cur_word;
        root_task  = root_q;
        state_d    = last_entry ? S_GAP : S_PRESENT;
      end
      S_GAP:  state_d = S_END;
      S_END: begin
        app_end = 1'b1;
        state_d = S_TAIL;
      end
      S_TAIL: state_d = (rep_q <= 16'd1) ? S_IDLE : S_PRESENT;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // Matrix storage; only writable while idle, cleared by reset
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && (state_q == S_IDLE)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Position, edge counter, repetition counter, root hold and done pulse
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      row_q  <= '0;
      col_q  <= '0;
      edge_q <= '0;
      rep_q  <= '0;
      root_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (start) begin
          if (num_apps == 16'd0) begin
            done_q <= 1'b1;
          end else begin
            rep_q  <= num_apps;
            row_q  <= '0;
            col_q  <= '0;
            edge_q <= '0;
            root_q <= 1'b0;
          end
        end
      end else if (abort) begin
        row_q  <= '0;
        col_q  <= '0;
        edge_q <= '0;
        rep_q  <= '0;
        root_q <= 1'b0;
      end else begin
        case (state_q)
          S_PRESENT: begin
            // root flag is latched so HOLD repeats the PRESENT decision
            root_q <= cur_nz && (edge_q == '0);
            if (cur_nz && (edge_q != EC_MAX)) edge_q <= edge_q + CW'(1);
          end
          S_HOLD: begin
            if (!last_entry) begin
              if (col_q == LAST) begin
                col_q <= '0;
                row_q <= row_q + AW'(1);
              end else begin
                col_q <= col_q + AW'(1);
              end
            end
          end
          S_TAIL: begin
            rep_q <= rep_q - 16'd1;
            row_q <= '0;
            col_q <= '0;
            // keep the final count visible after the last application
            if (rep_q > 16'd1) edge_q <= '0;
            else               done_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_task_graph_streamer.sv
// Self-checking bench: a per-cycle expected trace is generated from the
// matrix contents and the streaming rules, then compared on every falling edge.
module tb_task_graph_streamer;

  localparam int NV = 4;
  localparam int W  = 32;
  localparam int AW = 2;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          wr_en;
  logic [AW-1:0] wr_row, wr_col;
  logic [W-1:0]  wr_data;
  logic          start;
  logic [15:0]   num_apps;
  logic          abort;
  logic [W-1:0]  task_array;
  logic          root_task;
  logic [AW-1:0] row, col;
  logic          app_end, busy, done;
  logic [CW-1:0] edge_count;

  task_graph_streamer dut (
    .clk(clk), .rst_b(rst_b), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .start(start), .num_apps(num_apps), .abort(abort),
    .task_array(task_array), .root_task(root_task), .row(row), .col(col),
    .app_end(app_end), .busy(busy), .done(done), .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          busy;
    bit          done;
    bit          app_end;
    bit          root;
    bit          rc;
    logic [31:0] ta;
    int          row;
    int          col;
    int          ec;
  } rec_t;

  rec_t        plan[$];
  rec_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          n_app_end = 0, n_done = 0, n_root = 0;
  logic [31:0] m_mat [NV][NV];
  int          m_ec = 0;
  bit          force_wr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic rec_t mk(bit b, logic [31:0] ta, int r, int c, bit rc,
                              bit rt, bit ae, bit dn, int ec);
    rec_t x;
    x.busy = b; x.ta = ta; x.row = r; x.col = c; x.rc = rc;
    x.root = rt; x.app_end = ae; x.done = dn; x.ec = ec;
    return x;
  endfunction

  // Expected outputs cycle by cycle: record 0 is the idle cycle in which start
  // is driven, record 1 is the first presented entry.
  function automatic void build_plan(input int n, input int abort_at);
    int ec;
    logic [31:0] v;
    bit rt;
    plan.delete();
    plan.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, m_ec));
    ec = m_ec;
    if (n != 0) begin
      for (int a = 0; a < n; a++) begin
        ec = 0;
        for (int k = 0; k < NV * NV; k++) begin
          v  = m_mat[k / NV][k % NV];
          rt = (v != 0) && (ec == 0);
          plan.push_back(mk(1, v, k / NV, k % NV, 1, rt, 0, 0, ec));
          if ((v != 0) && (ec < (1 << CW) - 1)) ec++;
          plan.push_back(mk(1, v, k / NV, k % NV, 1, rt, 0, 0, ec));
        end
        plan.push_back(mk(1, 0, NV - 1, NV - 1, 1, 0, 0, 0, ec));
        plan.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, ec));
        plan.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, ec));
      end
    end
    plan.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, ec));
    plan.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ec));
    m_ec = ec;
    if (abort_at >= 0) begin
      while (plan.size() > abort_at + 1) void'(plan.pop_back());
      plan.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
      plan.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
      m_ec = 0;
    end
  endfunction

  // Compare process
  always @(negedge clk) begin
    rec_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
      chk("app_end", 32'(app_end), 32'(e.app_end));
      chk("root_task", 32'(root_task), 32'(e.root));
      chk("task_array", task_array, e.ta);
      chk("edge_count", 32'(edge_count), 32'(e.ec));
      if (e.rc) begin
        chk("row", 32'(row), 32'(e.row));
        chk("col", 32'(col), 32'(e.col));
      end
    end
  end

  // Pulse counters
  always @(negedge clk) begin
    if (rst_b) begin
      if (app_end)   n_app_end++;
      if (done)      n_done++;
      if (root_task) n_root++;
    end
  end

  task automatic wr(input int r, input int c, input logic [31:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_row = AW'(r); wr_col = AW'(c); wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    m_mat[r][c] = d;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_task_array"}, task_array, 0);
    chk({tag, "_root"}, 32'(root_task), 0);
    chk({tag, "_app_end"}, 32'(app_end), 0);
    chk({tag, "_row"}, 32'(row), 0);
    chk({tag, "_col"}, 32'(col), 0);
    chk({tag, "_edge_count"}, 32'(edge_count), 0);
  endtask

  task automatic run(input int n, input int abort_at, input int rst_at,
                     input bit do_wr, input int wr_r, input int wr_c, input logic [31:0] wr_d);
    @(posedge clk); #1;
    start = 1'b1;
    num_apps = 16'(n);
    wr_en = do_wr;
    if (do_wr) begin
      wr_row = AW'(wr_r); wr_col = AW'(wr_c); wr_data = wr_d;
      m_mat[wr_r][wr_c] = wr_d;
    end
    build_plan(n, abort_at);
    exp_q = plan;
    for (int i = 1; i < plan.size(); i++) begin
      @(posedge clk); #1;
      abort = (i == abort_at);
      if (plan[i].busy) begin
        start    = ($urandom_range(0, 3) == 0);
        num_apps = 16'($urandom_range(0, 5));
        if (force_wr) begin
          wr_en = 1'b1; wr_row = 0; wr_col = 0; wr_data = 32'd9;
        end else begin
          wr_en   = ($urandom_range(0, 3) == 0);
          wr_row  = AW'($urandom_range(0, NV - 1));
          wr_col  = AW'($urandom_range(0, NV - 1));
          wr_data = $urandom;
        end
      end else begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      if (i == rst_at) begin
        #2;
        rst_b = 1'b0;
        exp_q.delete();
        start = 1'b0; wr_en = 1'b0; abort = 1'b0;
        #1;
        check_all_zero("midrst");
        for (int r = 0; r < NV; r++)
          for (int c = 0; c < NV; c++) m_mat[r][c] = '0;
        m_ec = 0;
        return;
      end
    end
    start = 1'b0; wr_en = 1'b0; abort = 1'b0;
    @(negedge clk); #1;
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ae0, dn0, rt0, n, ab;
    rst_b = 1'b0; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    start = 1'b0; num_apps = '0; abort = 1'b0;
    for (int r = 0; r < NV; r++)
      for (int c = 0; c < NV; c++) m_mat[r][c] = '0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_b = 1'b1;

    // Symmetric example graph, one application
    wr(0, 1, 5); wr(0, 3, 7); wr(1, 0, 5); wr(1, 2, 6); wr(2, 1, 6); wr(3, 0, 7);
    ae0 = n_app_end; dn0 = n_done; rt0 = n_root;
    run(1, -1, -1, 0, 0, 0, 0);
    chk("t1_len", plan.size(), 38);
    chk("t1_root_ta", plan[3].ta, 5);
    chk("t1_root_p", 32'(plan[3].root), 1);
    chk("t1_root_h", 32'(plan[4].root), 1);
    chk("t1_end_at_34", 32'(plan[34].app_end), 1);
    chk("t1_ec_final", 32'(edge_count), 6);
    chk("t1_app_end_n", n_app_end - ae0, 1);
    chk("t1_done_n", n_done - dn0, 1);
    chk("t1_root_n", n_root - rt0, 2);

    // Three repetitions back to back
    ae0 = n_app_end; dn0 = n_done; rt0 = n_root;
    run(3, -1, -1, 0, 0, 0, 0);
    chk("t2_len", plan.size(), 108);
    chk("t2_end2", 32'(plan[69].app_end), 1);
    chk("t2_app_end_n", n_app_end - ae0, 3);
    chk("t2_done_n", n_done - dn0, 1);
    chk("t2_root_n", n_root - rt0, 6);

    // num_apps = 0
    ae0 = n_app_end; dn0 = n_done;
    run(0, -1, -1, 0, 0, 0, 0);
    chk("t3_len", plan.size(), 3);
    chk("t3_app_end_n", n_app_end - ae0, 0);
    chk("t3_done_n", n_done - dn0, 1);

    // Abort during entry (2,1), then replay
    dn0 = n_done;
    run(1, 19, -1, 0, 0, 0, 0);
    chk("t4_abort_row", plan[19].row, 2);
    chk("t4_abort_col", plan[19].col, 1);
    chk("t4_done_n", n_done - dn0, 0);
    rt0 = n_root;
    run(1, -1, -1, 0, 0, 0, 0);
    chk("t4_replay_root_n", n_root - rt0, 2);

    // Writes while busy are ignored
    force_wr = 1;
    run(1, -1, -1, 0, 0, 0, 0);
    force_wr = 0;
    run(1, -1, -1, 0, 0, 0, 0);
    chk("t5_m00", plan[1].ta, 0);

    // Write and start in the same idle cycle
    run(1, -1, -1, 1, 0, 2, 3);
    chk("t6_new_val", plan[5].ta, 3);

    // Reset mid-stream clears the matrix; then an all-zero stream
    run(2, -1, 40, 0, 0, 0, 0);
    @(negedge clk);
    rst_b = 1'b1;
    ae0 = n_app_end; rt0 = n_root;
    run(1, -1, -1, 0, 0, 0, 0);
    chk("t7_root_n", n_root - rt0, 0);
    chk("t7_app_end_n", n_app_end - ae0, 1);
    chk("t7_ec", 32'(edge_count), 0);

    // Randomized matrices, repetition counts and aborts
    for (int it = 0; it < 6; it++) begin
      for (int r = 0; r < NV; r++)
        for (int c = 0; c < NV; c++)
          wr(r, c, ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom);
      n  = $urandom_range(1, 3);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 35 * n) : -1;
      run(n, ab, -1, 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
